// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit:
//   - MIPS opcode constants used by the next-PC logic
//   - HALT_WORD, the encoding that stops fetch
//   - fetch FSM state encoding
package instr_fetch_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Handshake between the fetch unit and the multi-cycle CPU.
//   instrword : current instruction (fetch -> CPU)
//   newinstr  : one-cycle pulse, new instruction valid (fetch -> CPU)
//   instrdone : CPU finished the current instruction (CPU -> fetch)
//   aluzero   : ALU zero flag, valid with instrdone (CPU -> fetch)
interface instr_fetch_unit_if;
  logic [31:0] instrword;
  logic        newinstr;
  logic        instrdone;
  logic        aluzero;

  modport master (output instrword, output newinstr,
                  input  instrdone, input  aluzero);
  modport slave  (input  instrword, input  newinstr,
                  output instrdone, output aluzero);
endinterface

// File: rtl/instr_fetch_unit_next_pc_logic.sv
// Combinational next-PC computation for MIPS branch/jump.
//   pc        : address of the current instruction
//   instrword : current instruction
//   aluzero   : ALU zero flag for the current instruction
//   next_pc   : address of the next instruction
module next_pc_logic
  import instr_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instrword,
  input  logic        aluzero,
  output logic [31:0] next_pc
);

  logic [31:0] pc4;
  logic [31:0] br_off;
  logic [5:0]  opcode;

  assign pc4    = pc + 32'd4;
  assign opcode = instrword[31:26];
  // sign-extended word offset converted to a byte offset
  assign br_off = {{14{instrword[15]}}, instrword[15:0], 2'b00};

  always_comb begin
    next_pc = pc4;
    case (opcode)
      OP_BEQ:  if (aluzero)  next_pc = pc4 + br_off;
      OP_BNE:  if (!aluzero) next_pc = pc4 + br_off;
      OP_J:    next_pc = {pc4[31:28], instrword[25:0], 2'b00};
      default: next_pc = pc4;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage for mipscpu: PC, loadable instruction memory, next-PC
// logic, and the handshake with the CPU's multi-cycle control FSM.
//   clk, rst            : clock, synchronous active-high reset
//   run                 : level enable for fetch
//   imem_we/waddr/wdata : instruction memory write port
//   cpu                 : instrword/newinstr out, instrdone/aluzero in
//   pc                  : current PC
//   halted              : fetch stopped (halt word, bad PC or timeout)
//   fault               : stop caused by timeout or out-of-range PC
//
// state | meaning
// IDLE  | waiting for run
// FETCH | read imem[pc] into instrword, or fault on out-of-range pc
// ISSUE | newinstr high, wait counter cleared
// WAIT  | waiting for instrdone; counts toward timeout
// HALT  | stopped until reset
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int          IMEM_DEPTH   = 128,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          WAIT_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  imem_we,
  input  logic [6:0]            imem_waddr,
  input  logic [31:0]           imem_wdata,
  instr_fetch_unit_if.master    cpu,
  output logic [31:0]           pc,
  output logic                  halted,
  output logic                  fault
);

  localparam int CW = $clog2(WAIT_TIMEOUT + 1);

  logic [31:0] imem [IMEM_DEPTH];

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instrword_q, instrword_d;
  logic         newinstr_q, newinstr_d;
  logic         halted_q, halted_d;
  logic         fault_q, fault_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]  next_pc;

  next_pc_logic u_next_pc (
    .pc        (pc_q),
    .instrword (instrword_q),
    .aluzero   (cpu.aluzero),
    .next_pc   (next_pc)
  );

  // Memory survives reset; a same-cycle write is not seen by FETCH.
  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_waddr] <= imem_wdata;
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instrword_d = instrword_q;
    newinstr_d  = 1'b0;
    halted_d    = halted_q;
    fault_d     = fault_q;
    wait_cnt_d  = wait_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (|pc_q[31:9]) begin
          halted_d = 1'b1;
          fault_d  = 1'b1;
          state_d  = ST_HALT;
        end else begin
          instrword_d = imem[pc_q[8:2]];
          newinstr_d  = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        // instrdone has priority over a timeout in the same cycle
        if (cpu.instrdone) begin
          if (instrword_q == HALT_WORD) begin
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = run ? ST_FETCH : ST_IDLE;
          end
        end else if (wait_cnt_q == CW'(WAIT_TIMEOUT - 1)) begin
          halted_d = 1'b1;
          fault_d  = 1'b1;
          state_d  = ST_HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      instrword_q <= '0;
      newinstr_q  <= 1'b0;
      halted_q    <= 1'b0;
      fault_q     <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instrword_q <= instrword_d;
      newinstr_q  <= newinstr_d;
      halted_q    <= halted_d;
      fault_q     <= fault_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign cpu.instrword = instrword_q;
  assign cpu.newinstr  = newinstr_q;
  assign pc            = pc_q;
  assign halted        = halted_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        run;
  logic        imem_we;
  logic [6:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [31:0] pc;
  logic        halted;
  logic        fault;

  int checks   = 0;
  int failures = 0;

  instr_fetch_unit_if ifc ();

  instr_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu        (ifc),
    .pc         (pc),
    .halted     (halted),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
    tick();
    imem_we = 1'b0;
  endtask

  // returns number of cycles until newinstr is seen (bounded)
  task automatic wait_issue(output int cnt);
    cnt = 0;
    while (cnt < 20 && ifc.newinstr !== 1'b1) begin
      tick();
      cnt++;
    end
    chk("issue_seen", {31'd0, ifc.newinstr}, 32'd1);
  endtask

  // instrdone n cycles after the newinstr cycle
  task automatic complete(input int n, input logic az);
    repeat (n) tick();
    ifc.instrdone = 1'b1; ifc.aluzero = az;
    tick();
    ifc.instrdone = 1'b0; ifc.aluzero = 1'b0;
  endtask

  int  cnt;
  logic seen;

  initial begin
    rst = 1'b1; run = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    ifc.instrdone = 1'b0; ifc.aluzero = 1'b0;
    tick();
    wr(7'd0,  32'h8C01_0004);  // lw
    wr(7'd1,  32'h0800_0004);  // j 0x10
    wr(7'd2,  32'h1422_FFFE);  // bne -2
    wr(7'd3,  32'h0800_0010);  // j 0x40
    wr(7'd4,  32'h1022_0003);  // beq +3
    wr(7'd5,  32'h0800_0003);  // j 0x0C
    wr(7'd8,  32'h0800_0002);  // j 0x08
    wr(7'd16, 32'hFFFF_FFFF);  // halt
    chk("rst_pc", pc, 32'h0);
    chk("rst_instrword", ifc.instrword, 32'h0);
    chk("rst_newinstr", {31'd0, ifc.newinstr}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);

    // program walk
    rst = 1'b0; run = 1'b1;
    wait_issue(cnt);
    chk("first_issue_cycle", cnt, 32'd2);
    chk("first_pc", pc, 32'h0);
    chk("first_instrword", ifc.instrword, 32'h8C01_0004);
    complete(3, 1'b0);
    chk("lw_next_pc", pc, 32'h4);
    wait_issue(cnt);
    chk("issue_spacing", cnt, 32'd1);
    chk("j_instrword", ifc.instrword, 32'h0800_0004);
    complete(1, 1'b0);
    chk("j_to_10", pc, 32'h10);
    wait_issue(cnt);
    complete(2, 1'b1);
    chk("beq_taken", pc, 32'h20);
    wait_issue(cnt);
    complete(1, 1'b0);
    chk("j_to_08", pc, 32'h08);
    wait_issue(cnt);
    chk("bne_instrword", ifc.instrword, 32'h1422_FFFE);
    complete(1, 1'b0);
    chk("bne_taken_neg", pc, 32'h04);
    wait_issue(cnt);
    complete(1, 1'b1);
    chk("j_to_10_again", pc, 32'h10);
    wait_issue(cnt);
    complete(1, 1'b0);
    chk("beq_not_taken", pc, 32'h14);
    wait_issue(cnt);
    complete(1, 1'b0);
    chk("j_to_0c", pc, 32'h0C);
    wait_issue(cnt);
    complete(1, 1'b0);
    chk("j_target_40", pc, 32'h40);
    wait_issue(cnt);
    chk("halt_instrword", ifc.instrword, 32'hFFFF_FFFF);
    complete(2, 1'b0);
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_fault", {31'd0, fault}, 32'd0);
    chk("halt_pc", pc, 32'h40);
    seen = 1'b0;
    repeat (8) begin tick(); if (ifc.newinstr) seen = 1'b1; end
    chk("halt_no_issue", {31'd0, seen}, 32'd0);
    chk("halt_sticky", {31'd0, halted}, 32'd1);

    // timeout
    rst = 1'b1; tick(); tick();
    chk("rst2_halted", {31'd0, halted}, 32'd0);
    rst = 1'b0;
    wait_issue(cnt);
    repeat (16) tick();
    chk("timeout_not_yet", {31'd0, halted}, 32'd0);
    tick();
    chk("timeout_halted", {31'd0, halted}, 32'd1);
    chk("timeout_fault", {31'd0, fault}, 32'd1);
    chk("timeout_pc", pc, 32'h0);

    // instrdone on the last WAIT cycle beats the timeout
    rst = 1'b1; tick(); tick();
    chk("rst3_fault", {31'd0, fault}, 32'd0);
    rst = 1'b0;
    wait_issue(cnt);
    complete(16, 1'b0);
    chk("late_done_halted", {31'd0, halted}, 32'd0);
    chk("late_done_pc", pc, 32'h4);
    wait_issue(cnt);
    chk("late_done_next", ifc.instrword, 32'h0800_0004);

    // out-of-range PC
    rst = 1'b1; tick();
    wr(7'd0, 32'h0800_0080);   // j 0x200
    tick();
    rst = 1'b0;
    wait_issue(cnt);
    complete(1, 1'b0);
    chk("oor_pc", pc, 32'h200);
    chk("oor_not_yet", {31'd0, halted}, 32'd0);
    tick();
    chk("oor_halted", {31'd0, halted}, 32'd1);
    chk("oor_fault", {31'd0, fault}, 32'd1);
    chk("oor_newinstr", {31'd0, ifc.newinstr}, 32'd0);
    rst = 1'b1; tick();
    chk("rst4_pc", pc, 32'h0);
    chk("rst4_halted", {31'd0, halted}, 32'd0);
    chk("rst4_fault", {31'd0, fault}, 32'd0);

    // write collides with fetch of the same word
    wr(7'd0, 32'h8C01_0004);
    rst = 1'b0;
    tick();                    // now in FETCH
    imem_we = 1'b1; imem_waddr = 7'd0; imem_wdata = 32'h8C02_0008;
    tick();
    imem_we = 1'b0;
    chk("collision_newinstr", {31'd0, ifc.newinstr}, 32'd1);
    chk("collision_old", ifc.instrword, 32'h8C01_0004);
    rst = 1'b1; tick();
    rst = 1'b0;
    wait_issue(cnt);
    chk("refetch_new", ifc.instrword, 32'h8C02_0008);

    // run dropped mid-instruction
    tick();
    run = 1'b0;
    complete(1, 1'b0);
    chk("run_off_pc", pc, 32'h4);
    seen = 1'b0;
    repeat (5) begin tick(); if (ifc.newinstr) seen = 1'b1; end
    chk("run_off_no_issue", {31'd0, seen}, 32'd0);
    chk("run_off_halted", {31'd0, halted}, 32'd0);
    run = 1'b1;
    wait_issue(cnt);
    chk("run_on_latency", cnt, 32'd2);
    chk("run_on_instrword", ifc.instrword, 32'h0800_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Upstream fetch stage for mipscpu. Holds the PC, an internal loadable instruction memory and the branch/jump next-PC logic. Drives instrword and a one-cycle newinstr pulse into the CPU. Waits for the CPU's multi-cycle control FSM to report completion before advancing the PC.

Parameters:
IMEM_DEPTH, 128, instruction memory depth in 32-bit words; word index is pc[8:2].
RESET_PC, 32'h0000_0000, PC value after reset.
WAIT_TIMEOUT, 16, maximum cycles in WAIT before the unit faults.
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
run  in  1  level enable; fetch proceeds while high.
imem_we  in  1  instruction memory write strobe.
imem_waddr  in  7  instruction memory word address for writes.
imem_wdata  in  32  instruction memory write data.
instrdone  in  1  CPU has finished the current instruction (single-cycle pulse).
aluzero  in  1  ALU zero flag; sampled together with instrdone.
instrword  out  32  registered current instruction, to mipscpu.instrword.
newinstr  out  1  one-cycle pulse, to mipscpu.newinstr.
pc  out  32  current PC.
halted  out  1  fetch stopped, by HALT_WORD, out-of-range PC or timeout.
fault  out  1  set only by a timeout or an out-of-range PC.

Behaviour:
- Reset (rst sampled high at clk):
  - pc=RESET_PC, instrword=0, newinstr=0, halted=0, fault=0, wait counter=0, state=IDLE.
  - Instruction memory contents are NOT cleared.
  - Reset in any state, including WAIT and HALT, aborts the current instruction immediately.
- States: IDLE, FETCH, ISSUE, WAIT, HALT.
- IDLE: if run=1, go to FETCH next cycle. Otherwise stay.
- FETCH:
  - If pc[31:9]!=0, set halted=1 and fault=1, go to HALT.
  - Otherwise instrword <= imem[pc[8:2]], go to ISSUE.
- ISSUE:
  - newinstr=1 for exactly this cycle.
  - Wait counter cleared. Go to WAIT.
  - instrdone is ignored in ISSUE.
- WAIT: wait counter increments each cycle.
  - On instrdone=1, compute next PC from instrword and aluzero (pc4 = pc+4, modulo 2^32):
    - opcode 4 (beq) with aluzero=1: pc4 + (sext(imm16)<<2).
    - opcode 5 (bne) with aluzero=0: pc4 + (sext(imm16)<<2).
    - opcode 2 (j): {pc4[31:28], instrword[25:0], 2'b00}.
    - all other opcodes: pc4.
  - Then, with pc updated in the same edge:
    - if instrword==HALT_WORD: pc is not updated, halted=1, go to HALT;
    - else if run=1: go to FETCH;
    - else: go to IDLE.
  - If the counter reaches WAIT_TIMEOUT without instrdone: halted=1, fault=1, go to HALT.
  - instrdone and timeout in the same cycle: instrdone wins.
- HALT: absorbing; leaves only on rst. newinstr stays 0.
- run deasserted mid-instruction: the current instruction completes normally, then the unit goes to IDLE.
- Instruction memory writes:
  - Synchronous, accepted in any state.
  - A write and a FETCH to the same word in the same cycle: FETCH gets the old data.
- Throughput: with instrdone arriving N cycles after newinstr, issue-to-issue spacing is N+2 cycles.
- pc[1:0] is always 0 by construction.

Decomposition:
- Shared package holds:
  - opcode constants: OP_RTYPE=0, OP_J=2, OP_BEQ=4, OP_BNE=5, OP_LW=35, OP_SW=43;
  - HALT_WORD;
  - fetch state encoding.
- One combinational sub-module, next_pc_logic: inputs pc, instrword, aluzero; output next pc. Reused by any future pipelined variant.

Test Plan:
- Reset then run=1, imem[0]=0x8C010004 (lw), instrdone 3 cycles after newinstr -> newinstr pulses at cycle 2 and cycle 7; pc 0 -> 4.
- beq at pc=0x10 with imm=0x0003, aluzero=1 -> pc=0x20; same instruction with aluzero=0 -> pc=0x14.
- bne at pc=0x08 with imm=0xFFFE, aluzero=0 -> pc=0x04 (negative offset).
- j at pc=0x0C with target 0x0000010 -> pc=0x40; imem[16]=HALT_WORD -> halted=1, fault=0, pc stays 0x40, no further newinstr.
- instrdone withheld -> halted=1 and fault=1 exactly WAIT_TIMEOUT cycles after entering WAIT; next pc unchanged; rst then clears halted, fault and pc.
- Jump to 0x200 (out of range) -> FETCH sets halted=1, fault=1. Separately: imem write to the word being fetched in the same cycle -> instrword holds the old word; a refetch gets the new word.
